sad_min_select: RTL and testbench

Motion-estimation best-match selector; sits directly downstream of the 8x8 SAD processing-element array. It consumes one 14-bit SAD per accepted cycle, one per candidate position of the search window in raster order. It tracks the minimum SAD and its candidate position, then reports the best motion vector with a one-cycle `done` pulse. Results are held until the next search starts.

---
 rtl/me_pkg.sv | 17 +
 rtl/raster_counter.sv | 48 ++++
 rtl/sad_min_select.sv | 130 +++++++++++++
 tb/tb_sad_min_select.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/me_pkg.sv
// Shared motion-estimation definitions, used by the PE array and the
// best-match selector.
//   SAD_W       : SAD result width produced by the 8x8 PE array
//   MV_W        : signed motion-vector component width
//   sel_state_t : best-match selector FSM states
package me_pkg;

    localparam int SAD_W = 14;
    localparam int MV_W  = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sel_state_t;

endpackage

// File: rtl/raster_counter.sv
// Raster-order candidate position counter for one search window.
// Ports:
//   clk, rst          : clock, asynchronous active-low reset
//   clear             : return to (0,0); has priority over advance
//   advance           : step one position in raster order
//   x_idx, y_idx      : current candidate column / row
//   last              : current position is the final one (RANGE_X-1, RANGE_Y-1)
module raster_counter #(
    parameter int RANGE_X = 16,
    parameter int RANGE_Y = 16,
    localparam int XW = $clog2(RANGE_X),
    localparam int YW = $clog2(RANGE_Y)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          advance,
    output logic [XW-1:0] x_idx,
    output logic [YW-1:0] y_idx,
    output logic          last
);

    logic x_last;
    logic y_last;

    assign x_last = (x_idx == XW'(RANGE_X - 1));
    assign y_last = (y_idx == YW'(RANGE_Y - 1));
    assign last   = x_last && y_last;

    // Ranges are powers of two, so y_idx wraps on its own after the last row.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_idx <= '0;
            y_idx <= '0;
        end else if (clear) begin
            x_idx <= '0;
            y_idx <= '0;
        end else if (advance) begin
            if (x_last) begin
                x_idx <= '0;
                y_idx <= y_idx + 1'b1;
            end else begin
                x_idx <= x_idx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sad_min_select.sv
// Motion-estimation best-match selector. Takes one SAD per accepted cycle in
// raster order over a RANGE_X x RANGE_Y window, keeps the strict minimum
// (earliest candidate wins ties) and reports it as a signed motion vector.
// Ports:
//   clk, rst            : clock, asynchronous active-low reset
//   start               : begin a search (honoured in IDLE only)
//   abort               : cancel a running search, results untouched
//   sad_valid, sad      : candidate SAD stream
//   busy                : search in progress (cycle after start .. done cycle)
//   done                : one-cycle pulse, best_* are final
//   best_sad            : minimum SAD of the last completed search
//   best_mvx, best_mvy  : signed offset of that minimum from the window centre
module sad_min_select
    import me_pkg::*;
#(
    parameter int SAD_W   = me_pkg::SAD_W,
    parameter int RANGE_X = 16,
    parameter int RANGE_Y = 16,
    parameter int MV_W    = me_pkg::MV_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   sad_valid,
    input  logic [SAD_W-1:0]       sad,
    output logic                   busy,
    output logic                   done,
    output logic [SAD_W-1:0]       best_sad,
    output logic signed [MV_W-1:0] best_mvx,
    output logic signed [MV_W-1:0] best_mvy
);

    localparam int XW = $clog2(RANGE_X);
    localparam int YW = $clog2(RANGE_Y);

    sel_state_t state, state_nxt;
    logic       clear, accept, last;

    logic [XW-1:0]    x_idx, min_x, fin_x;
    logic [YW-1:0]    y_idx, min_y, fin_y;
    logic [SAD_W-1:0] min_sad, fin_sad;
    logic             cand_lt;

    raster_counter #(
        .RANGE_X (RANGE_X),
        .RANGE_Y (RANGE_Y)
    ) u_raster (
        .clk     (clk),
        .rst     (rst),
        .clear   (clear),
        .advance (accept),
        .x_idx   (x_idx),
        .y_idx   (y_idx),
        .last    (last)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // abort wins over a same-cycle sample; samples outside RUN are dropped.
    always_comb begin
        state_nxt = state;
        clear     = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                    clear     = 1'b1;
                end
            end
            RUN: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (sad_valid) begin
                    accept = 1'b1;
                    if (last) state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Strict less-than keeps the earlier raster position on ties.
    assign cand_lt = accept && (sad < min_sad);
    assign fin_sad = cand_lt ? sad   : min_sad;
    assign fin_x   = cand_lt ? x_idx : min_x;
    assign fin_y   = cand_lt ? y_idx : min_y;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            min_sad <= '1;
            min_x   <= '0;
            min_y   <= '0;
        end else if (clear) begin
            min_sad <= '1;
            min_x   <= '0;
            min_y   <= '0;
        end else if (cand_lt) begin
            min_sad <= sad;
            min_x   <= x_idx;
            min_y   <= y_idx;
        end
    end

    // Outputs are registered from the next state, so the final sample's
    // compare folds straight into best_* on the edge that enters DONE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            best_sad <= '1;
            best_mvx <= '0;
            best_mvy <= '0;
        end else begin
            busy <= (state_nxt != IDLE);
            done <= (state_nxt == DONE);
            if (state_nxt == DONE) begin
                best_sad <= fin_sad;
                best_mvx <= MV_W'(fin_x) - MV_W'(RANGE_X / 2);
                best_mvy <= MV_W'(fin_y) - MV_W'(RANGE_Y / 2);
            end
        end
    end

endmodule

// File: tb/tb_sad_min_select.sv
// Scoreboard bench for sad_min_select: each full search pushes its expected
// result and done cycle; a negedge monitor pops on every done pulse.
module tb_sad_min_select;

    localparam int SW = 14;
    localparam int RX = 16;
    localparam int RY = 16;
    localparam int MW = 6;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 start = 1'b0;
    logic                 abort = 1'b0;
    logic                 sad_valid = 1'b0;
    logic [SW-1:0]        sad = '0;
    logic                 busy, done;
    logic [SW-1:0]        best_sad;
    logic signed [MW-1:0] best_mvx, best_mvy;

    int cyc    = 0;
    int errors = 0;
    int checks = 0;

    typedef struct {
        int sad;
        int mx;
        int my;
        int cyc;
    } exp_t;
    exp_t sb[$];

    sad_min_select #(
        .SAD_W   (SW),
        .RANGE_X (RX),
        .RANGE_Y (RY),
        .MV_W    (MW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .sad_valid (sad_valid),
        .sad       (sad),
        .busy      (busy),
        .done      (done),
        .best_sad  (best_sad),
        .best_mvx  (best_mvx),
        .best_mvy  (best_mvy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int pat_sad(input int p, input int x, input int y);
        case (p)
            0:       return (x == 3 && y == 5) ? 20 : 100;
            1:       return ((x == 2 && y == 0) || (x == 9 && y == 12)) ? 7 : 50;
            2:       return (x == 15 && y == 15) ? 0 : 1000;
            default: return 16383;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // start pulse; optionally with a same-cycle sad_valid carrying SAD 0,
    // which must be ignored
    task automatic begin_search(input bit valid_on_start);
        start     = 1'b1;
        sad_valid = valid_on_start;
        sad       = '0;
        tick();
        start     = 1'b0;
        sad_valid = 1'b0;
    endtask

    task automatic feed(input int p, input bit toggle, input int n);
        for (int i = 0; i < n; i++) begin
            sad_valid = 1'b1;
            sad       = SW'(pat_sad(p, i % RX, i / RX));
            tick();
            if (toggle) begin
                sad_valid = 1'b0;
                sad       = '0;
                tick();
            end
        end
        sad_valid = 1'b0;
    endtask

    task automatic full_search(input int p, input bit toggle, input bit vos,
                               input int es, input int emx, input int emy);
        exp_t e;
        e.sad = es;
        e.mx  = emx;
        e.my  = emy;
        // start cycle counts as 1: done on cycle 258 (or 513 when toggled)
        e.cyc = cyc + (toggle ? 512 : 257);
        sb.push_back(e);
        begin_search(vos);
        chk("busy_after_start", busy, 1);
        feed(p, toggle, RX * RY);
        for (int k = 0; k < 20 && sb.size() != 0; k++) tick();
        if (sb.size() != 0) begin
            chk("done_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_best_sad"}, best_sad, 16383);
        chk({tag, "_best_mvx"}, best_mvx, 0);
        chk({tag, "_best_mvy"}, best_mvy, 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("done_cycle", cyc, e.cyc);
                chk("best_sad", best_sad, e.sad);
                chk("best_mvx", best_mvx, e.mx);
                chk("best_mvy", best_mvy, e.my);
                chk("busy_in_done", busy, 1);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tick();
        tick();
        check_reset_outputs("reset");
        rst = 1'b1;
        tick();
        tick();

        // single unique minimum
        full_search(0, 1'b0, 1'b0, 20, -5, -3);
        // tie: earlier raster position wins
        full_search(1, 1'b0, 1'b0, 7, -6, -8);
        // sad_valid toggling, minimum at the last position
        full_search(2, 1'b1, 1'b0, 0, 7, 7);
        // all-ones SAD never beats the initial minimum; sample on the start
        // cycle is ignored
        full_search(3, 1'b0, 1'b1, 16383, -8, -8);

        // abort after 100 samples, with a same-cycle sample of SAD 0
        begin_search(1'b0);
        feed(0, 1'b0, 100);
        abort     = 1'b1;
        sad_valid = 1'b1;
        sad       = '0;
        tick();
        abort     = 1'b0;
        sad_valid = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_keep_sad", best_sad, 16383);
        chk("abort_keep_mvx", best_mvx, -8);
        chk("abort_keep_mvy", best_mvy, -8);
        tick();
        tick();
        tick();
        full_search(1, 1'b0, 1'b0, 7, -6, -8);

        // reset in the middle of a search
        begin_search(1'b0);
        feed(0, 1'b0, 50);
        #2 rst = 1'b0;
        #1;
        check_reset_outputs("midrun_reset");
        tick();
        rst = 1'b1;
        tick();
        full_search(0, 1'b0, 1'b0, 20, -5, -3);

        tick();
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
